// File: rtl/nibbler_sequencer_if.sv
// rtl/nibbler_sequencer_if.sv - program-fetch and datapath-control bundle of the Nibbler sequencer
interface nibbler_sequencer_if #(
   parameter int PC_W = 12,
   parameter int N    = 4
);
   logic [7:0]      instr;
   logic            prog_valid;
   logic            C;
   logic            Z;
   logic [PC_W-1:0] pc;
   logic            prog_req;
   logic            ir_load;
   logic [1:0]      alu_op;
   logic            accu_we;
   logic            flags_we;
   logic            mem_we;
   logic            port_rd;
   logic            port_wr;
   logic [1:0]      port_sel;
   logic [N-1:0]    imm;
   logic            halted;

   modport master (
      input  instr, prog_valid, C, Z,
      output pc, prog_req, ir_load, alu_op, accu_we, flags_we, mem_we,
             port_rd, port_wr, port_sel, imm, halted
   );

   modport slave (
      output instr, prog_valid, C, Z,
      input  pc, prog_req, ir_load, alu_op, accu_we, flags_we, mem_we,
             port_rd, port_wr, port_sel, imm, halted
   );
endinterface

// File: rtl/nibbler_sequencer.sv
// rtl/nibbler_sequencer.sv - fetch/execute control unit of the Nibbler 4-bit processor
module nibbler_sequencer #(
   parameter int PC_W = 12,
   parameter int N    = 4
) (
   input  logic                clk,
   input  logic                reset,
   nibbler_sequencer_if.master bus
);
   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_EXEC   = 2'd1,
      S_OPND   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LIT  = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_NORI = 4'h3;
   localparam logic [3:0] OP_CMPI = 4'h4;
   localparam logic [3:0] OP_LD   = 4'h5;
   localparam logic [3:0] OP_ST   = 4'h6;
   localparam logic [3:0] OP_IN   = 4'h7;
   localparam logic [3:0] OP_OUT  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_JC   = 4'hA;
   localparam logic [3:0] OP_JNC  = 4'hB;
   localparam logic [3:0] OP_JZ   = 4'hC;
   localparam logic [3:0] OP_JNZ  = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] ALU_PASS = 2'd0;
   localparam logic [1:0] ALU_ADD  = 2'd1;
   localparam logic [1:0] ALU_NOR  = 2'd2;
   localparam logic [1:0] ALU_CMP  = 2'd3;
   localparam logic [1:0] NO_PORT  = 2'd3;

   state_t          state_q;
   logic [PC_W-1:0] pc_q;
   logic [7:0]      ir_q;
   logic [1:0]      alu_op_q;
   logic            accu_we_q;
   logic            flags_we_q;
   logic            mem_we_q;
   logic            port_rd_q;
   logic            port_wr_q;
   logic [1:0]      port_sel_q;
   logic            halted_q;

   logic [3:0]      new_op;
   logic [1:0]      new_sel;
   logic            new_is_jump;
   logic            new_port_ok;
   logic [1:0]      alu_op_d;
   logic            accu_we_d;
   logic            flags_we_d;
   logic            mem_we_d;
   logic            port_rd_d;
   logic            port_wr_d;
   logic [1:0]      port_sel_d;
   logic [PC_W-1:0] pc_inc_d;
   logic [PC_W-1:0] pc_jmp_d;
   logic            jump_taken_d;

   // Strobe decode is taken from the word arriving in FETCH so the strobes
   // come out of flops during the single EXEC cycle that follows.
   always_comb begin
      new_op      = bus.instr[7:4];
      new_sel     = bus.instr[1:0];
      new_is_jump = (new_op >= OP_JMP) && (new_op <= OP_JNZ);
      new_port_ok = (new_sel != NO_PORT);
      alu_op_d    = ALU_PASS;
      accu_we_d   = 1'b0;
      flags_we_d  = 1'b0;
      mem_we_d    = 1'b0;
      port_rd_d   = 1'b0;
      port_wr_d   = 1'b0;
      port_sel_d  = NO_PORT;
      case (new_op)
         OP_LIT:  accu_we_d = 1'b1;
         OP_ADDI: begin
            accu_we_d  = 1'b1;
            flags_we_d = 1'b1;
            alu_op_d   = ALU_ADD;
         end
         OP_NORI: begin
            accu_we_d = 1'b1;
            alu_op_d  = ALU_NOR;
         end
         OP_CMPI: begin
            flags_we_d = 1'b1;
            alu_op_d   = ALU_CMP;
         end
         OP_LD:   accu_we_d = 1'b1;
         OP_ST:   mem_we_d  = 1'b1;
         OP_IN: begin
            port_sel_d = new_sel;
            port_rd_d  = new_port_ok;
            accu_we_d  = new_port_ok;
         end
         OP_OUT: begin
            port_sel_d = new_sel;
            port_wr_d  = new_port_ok;
         end
         default: ;
      endcase
   end

   // The jump target's high nibble comes from IR, its low byte straight from memory.
   always_comb begin
      pc_inc_d = pc_q + PC_W'(1);
      pc_jmp_d = PC_W'({ir_q[N-1:0], bus.instr});
      case (ir_q[7:4])
         OP_JMP:  jump_taken_d = 1'b1;
         OP_JC:   jump_taken_d = bus.C;
         OP_JNC:  jump_taken_d = ~bus.C;
         OP_JZ:   jump_taken_d = bus.Z;
         OP_JNZ:  jump_taken_d = ~bus.Z;
         default: jump_taken_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_FETCH;
         pc_q       <= '0;
         ir_q       <= 8'h00;
         alu_op_q   <= ALU_PASS;
         accu_we_q  <= 1'b0;
         flags_we_q <= 1'b0;
         mem_we_q   <= 1'b0;
         port_rd_q  <= 1'b0;
         port_wr_q  <= 1'b0;
         port_sel_q <= NO_PORT;
         halted_q   <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (bus.prog_valid) begin
                  ir_q <= bus.instr;
                  pc_q <= pc_inc_d;
                  if (new_is_jump) begin
                     state_q <= S_OPND;
                  end else begin
                     state_q    <= S_EXEC;
                     alu_op_q   <= alu_op_d;
                     accu_we_q  <= accu_we_d;
                     flags_we_q <= flags_we_d;
                     mem_we_q   <= mem_we_d;
                     port_rd_q  <= port_rd_d;
                     port_wr_q  <= port_wr_d;
                     port_sel_q <= port_sel_d;
                  end
               end
            end
            S_EXEC: begin
               alu_op_q   <= ALU_PASS;
               accu_we_q  <= 1'b0;
               flags_we_q <= 1'b0;
               mem_we_q   <= 1'b0;
               port_rd_q  <= 1'b0;
               port_wr_q  <= 1'b0;
               port_sel_q <= NO_PORT;
               if (ir_q[7:4] == OP_HALT) begin
                  state_q  <= S_HALTED;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= S_FETCH;
               end
            end
            S_OPND: begin
               if (bus.prog_valid) begin
                  pc_q    <= jump_taken_d ? pc_jmp_d : pc_inc_d;
                  state_q <= S_FETCH;
               end
            end
            S_HALTED: begin
               halted_q <= 1'b1;
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign bus.pc       = pc_q;
   assign bus.prog_req = (state_q == S_FETCH) || (state_q == S_OPND);
   assign bus.ir_load  = (state_q == S_FETCH) && bus.prog_valid;
   assign bus.alu_op   = alu_op_q;
   assign bus.accu_we  = accu_we_q;
   assign bus.flags_we = flags_we_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.port_rd  = port_rd_q;
   assign bus.port_wr  = port_wr_q;
   assign bus.port_sel = port_sel_q;
   assign bus.imm      = ir_q[N-1:0];
   assign bus.halted   = halted_q;
endmodule

// File: tb/tb_nibbler_sequencer.sv
// tb/tb_nibbler_sequencer.sv - directed and randomized checks of nibbler_sequencer against an instruction-level model
module tb_nibbler_sequencer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   nibbler_sequencer_if #(.PC_W(12), .N(4)) bus ();
   nibbler_sequencer #(.PC_W(12), .N(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;
   logic [11:0] m_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [4:0] obs_strobes();
      return {bus.accu_we, bus.flags_we, bus.mem_we, bus.port_rd, bus.port_wr};
   endfunction

   // {accu_we, flags_we, mem_we, port_rd, port_wr} straight from the opcode table
   function automatic logic [4:0] exp_strobes(input logic [3:0] op, input logic [1:0] sel);
      case (op)
         4'h1, 4'h3, 4'h5: return 5'b10000;
         4'h2:             return 5'b11000;
         4'h4:             return 5'b01000;
         4'h6:             return 5'b00100;
         4'h7:             return (sel == 2'd3) ? 5'b00000 : 5'b10010;
         4'h8:             return (sel == 2'd3) ? 5'b00000 : 5'b00001;
         default:          return 5'b00000;
      endcase
   endfunction

   function automatic logic jump_taken(input logic [3:0] op, input logic c, input logic z);
      return (op == 4'h9) || (op == 4'hA && c) || (op == 4'hB && !c) ||
             (op == 4'hC && z) || (op == 4'hD && !z);
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      bus.prog_valid = 1'b0;
      bus.instr = 8'h00;
      #1;
      chk("rst_pc", bus.pc, 0);
      chk("rst_strobes", obs_strobes(), 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_imm", bus.imm, 0);
      chk("rst_alu_op", bus.alu_op, 0);
      chk("rst_prog_req", bus.prog_req, 1);
      @(negedge clk);
      reset = 1'b1;
      m_pc = 12'h000;
   endtask

   task automatic fetch_word(input logic [7:0] w, input int stalls, input bit opcode);
      for (int i = 0; i < stalls; i++) begin
         bus.prog_valid = 1'b0;
         bus.instr = 8'($urandom);
         #1;
         chk("stall_pc", bus.pc, m_pc);
         chk("stall_prog_req", bus.prog_req, 1);
         chk("stall_ir_load", bus.ir_load, 0);
         chk("stall_strobes", obs_strobes(), 0);
         next_cycle();
      end
      bus.prog_valid = 1'b1;
      bus.instr = w;
      #1;
      chk("fetch_pc", bus.pc, m_pc);
      chk("fetch_prog_req", bus.prog_req, 1);
      if (opcode) chk("fetch_ir_load", bus.ir_load, 1);
      chk("fetch_strobes", obs_strobes(), 0);
      next_cycle();
      bus.prog_valid = 1'b0;
      m_pc = m_pc + 12'd1;
   endtask

   task automatic run_instr(input logic [7:0] w, input logic [7:0] lo, input int st0, input int st1);
      logic [3:0] op;
      op = w[7:4];
      fetch_word(w, st0, 1'b1);
      if (op >= 4'h9 && op <= 4'hD) begin
         fetch_word(lo, st1, 1'b0);
         if (jump_taken(op, bus.C, bus.Z)) m_pc = {w[3:0], lo};
         #1;
         chk("jump_pc", bus.pc, m_pc);
         chk("jump_strobes", obs_strobes(), 0);
      end else begin
         bus.prog_valid = 1'($urandom);
         #1;
         chk("exec_strobes", obs_strobes(), exp_strobes(op, w[1:0]));
         chk("exec_imm", bus.imm, w[3:0]);
         chk("exec_pc", bus.pc, m_pc);
         chk("exec_prog_req", bus.prog_req, 0);
         if (op == 4'h7 || op == 4'h8) chk("exec_port_sel", bus.port_sel, w[1:0]);
         if (op == 4'h1 || op == 4'h5 || (op == 4'h7 && w[1:0] != 2'd3)) chk("exec_alu", bus.alu_op, 0);
         if (op == 4'h2) chk("exec_alu", bus.alu_op, 1);
         if (op == 4'h3) chk("exec_alu", bus.alu_op, 2);
         if (op == 4'h4) chk("exec_alu", bus.alu_op, 3);
         next_cycle();
         bus.prog_valid = 1'b0;
      end
   endtask

   initial begin
      bus.C = 1'b0;
      bus.Z = 1'b0;
      do_reset();

      run_instr(8'h15, 8'h00, 0, 0);
      do_reset();
      run_instr(8'h15, 8'h00, 3, 0);

      do_reset();
      bus.Z = 1'b1;
      run_instr(8'hC9, 8'h3C, 0, 0);
      chk("jz_taken_pc", bus.pc, 12'h93C);
      do_reset();
      bus.Z = 1'b0;
      run_instr(8'hC9, 8'h3C, 0, 1);
      chk("jz_not_taken_pc", bus.pc, 12'h002);

      run_instr(8'h82, 8'h00, 0, 0);
      chk("out2_drop", bus.port_wr, 0);
      run_instr(8'h83, 8'h00, 1, 0);

      run_instr(8'h9F, 8'hFF, 0, 0);
      run_instr(8'h00, 8'h00, 0, 0);
      chk("wrap_pc", bus.pc, 12'h000);
      run_instr(8'hF0, 8'h00, 0, 0);
      for (int i = 0; i < 4; i++) begin
         bus.prog_valid = 1'($urandom);
         bus.instr = 8'($urandom);
         #1;
         chk("halt_flag", bus.halted, 1);
         chk("halt_prog_req", bus.prog_req, 0);
         chk("halt_pc", bus.pc, m_pc);
         chk("halt_strobes", obs_strobes(), 0);
         next_cycle();
      end

      do_reset();
      run_instr(8'h15, 8'h00, 0, 0);
      fetch_word(8'h64, 0, 1'b1);
      #1;
      chk("st_mem_we", bus.mem_we, 1);
      reset = 1'b0;
      #1;
      chk("abort_mem_we", bus.mem_we, 0);
      chk("abort_pc", bus.pc, 0);
      chk("abort_prog_req", bus.prog_req, 1);
      @(negedge clk);
      reset = 1'b1;
      m_pc = 12'h000;
      run_instr(8'h25, 8'h00, 0, 0);

      for (int i = 0; i < 300; i++) begin
         logic [7:0] w;
         w = {4'($urandom_range(0, 14)), 4'($urandom)};
         bus.C = 1'($urandom);
         bus.Z = 1'($urandom);
         run_instr(w, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      end
      run_instr(8'hF7, 8'h00, 0, 0);
      #1;
      chk("final_halt", bus.halted, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end
endmodule
